// File: rtl/window_pkg.sv
// Shared constants and helpers for the 3x3 window generator.
// Counter widths are derived from the image geometry through clog2.
package window_pkg;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned IMG_WIDTH_DEF  = 640;
    localparam int unsigned IMG_HEIGHT_DEF = 480;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

    localparam int unsigned COL_W_DEF = clog2(IMG_WIDTH_DEF);
    localparam int unsigned ROW_W_DEF = clog2(IMG_HEIGHT_DEF);

endpackage

// File: rtl/line_buffer.sv
// Single-line delay buffer with read-before-write at one address.
// Contents are never reset; the window generator masks stale data.
module line_buffer
    import window_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = IMG_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read returns the value stored before this cycle's write.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-scan 3x3 window generator: two line buffers feed three 3-deep
// column shift registers; only interior windows raise dout_valid.
// Optional window counter enabled by defining WINDOW_WIN_CNT_EN.
module window_3x3_gen
    import window_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
`ifdef WINDOW_WIN_CNT_EN
    ,
    localparam int unsigned WIN_CNT_W = clog2((IMG_WIDTH-2)*(IMG_HEIGHT-2)+1)
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
    output logic [DATA_W-1:0] p9,
    output logic              dout_valid
`ifdef WINDOW_WIN_CNT_EN
    ,
    output logic [WIN_CNT_W-1:0] win_count
`endif
);

    localparam int unsigned COL_W = clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = clog2(IMG_HEIGHT);

    logic [COL_W-1:0]  col, col_nxt, eff_col;
    logic [ROW_W-1:0]  row, row_nxt, eff_row;
    logic              sof_acc;
    logic              interior;
    logic [DATA_W-1:0] lb1_rd, lb2_rd;

    // An accepted sof pixel is forced to (0,0) whatever the counters say.
    assign sof_acc  = din_valid & sof;
    assign eff_col  = sof_acc ? '0 : col;
    assign eff_row  = sof_acc ? '0 : row;
    assign interior = (eff_col >= COL_W'(2)) && (eff_row >= ROW_W'(2));

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk   (clk),
        .we    (din_valid),
        .addr  (eff_col),
        .wdata (din),
        .rdata (lb1_rd)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_WIDTH)) u_lb2 (
        .clk   (clk),
        .we    (din_valid),
        .addr  (eff_col),
        .wdata (lb1_rd),
        .rdata (lb2_rd)
    );

    // Raster position of the pixel following the current accept.
    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (din_valid) begin
            if (eff_col == COL_W'(IMG_WIDTH-1)) begin
                col_nxt = '0;
                row_nxt = (eff_row == ROW_W'(IMG_HEIGHT-1)) ? '0 : eff_row + ROW_W'(1);
            end else begin
                col_nxt = eff_col + COL_W'(1);
                row_nxt = eff_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            dout_valid <= 1'b0;
            p1 <= '0; p2 <= '0; p3 <= '0;
            p4 <= '0; p5 <= '0; p6 <= '0;
            p7 <= '0; p8 <= '0; p9 <= '0;
        end else begin
            col        <= col_nxt;
            row        <= row_nxt;
            dout_valid <= din_valid & interior;
            if (din_valid) begin
                p1 <= p2; p2 <= p3; p3 <= lb2_rd;
                p4 <= p5; p5 <= p6; p6 <= lb1_rd;
                p7 <= p8; p8 <= p9; p9 <= din;
            end
        end
    end

`ifdef WINDOW_WIN_CNT_EN
    // Windows emitted since the last accepted sof; clear beats increment.
    always_ff @(posedge clk) begin
        if (!rst_n || sof_acc) begin
            win_count <= '0;
        end else if (dout_valid) begin
            win_count <= win_count + WIN_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomised bench for window_3x3_gen against a frame-array model
// (IMG_WIDTH=8, IMG_HEIGHT=6); honours WINDOW_WIN_CNT_EN.
module tb_window_3x3_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       sof;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic       dout_valid;
`ifdef WINDOW_WIN_CNT_EN
    logic [4:0] win_count;
`endif

    always #5 clk = ~clk;

    window_3x3_gen #(.DATA_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .p1         (p1), .p2 (p2), .p3 (p3),
        .p4         (p4), .p5 (p5), .p6 (p6),
        .p7         (p7), .p8 (p8), .p9 (p9),
        .dout_valid (dout_valid)
`ifdef WINDOW_WIN_CNT_EN
        ,
        .win_count  (win_count)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    // Model state: image as written this frame and the raster position.
    logic [7:0]  img [H][W];
    int          mrow = 0, mcol = 0;
    logic        exp_v = 1'b0;
    logic        exp_zero = 1'b0;
    logic [71:0] exp_taps = '0;
    int          exp_wc = 0;
    int          strobe_cnt = 0;
    logic [71:0] first_taps = '0, last_taps = '0, cap32 = '0;
    logic        got32 = 1'b0;

    function automatic logic [71:0] taps_now();
        return {p1, p2, p3, p4, p5, p6, p7, p8, p9};
    endfunction

    // Model update at each edge, compare 1 time unit later.
    always @(posedge clk) begin
        int r, c;
        logic prev_v;
        prev_v   = exp_v;
        exp_zero = 1'b0;
        if (!rst_n) begin
            mrow = 0; mcol = 0; exp_v = 1'b0; exp_zero = 1'b1;
            exp_wc = 0; strobe_cnt = 0; got32 = 1'b0;
        end else if (din_valid) begin
            if (sof) begin
                r = 0; c = 0; exp_wc = 0; strobe_cnt = 0; got32 = 1'b0;
            end else begin
                r = mrow; c = mcol;
                if (prev_v) exp_wc = exp_wc + 1;
            end
            img[r][c] = din;
            exp_v = (r >= 2) && (c >= 2);
            if (exp_v)
                exp_taps = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                            img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                            img[r][c-2],   img[r][c-1],   img[r][c]};
            mcol = c + 1; mrow = r;
            if (mcol == W) begin
                mcol = 0;
                mrow = (r == H-1) ? 0 : r + 1;
            end
            if (exp_v && r == 3 && c == 2) got32 = 1'b1;
        end else begin
            if (prev_v) exp_wc = exp_wc + 1;
            exp_v = 1'b0;
        end
        #1;
        nvec++;
        if (dout_valid !== exp_v) begin
            nerr++;
            $display("FAIL dout_valid: got %b want %b at %0t", dout_valid, exp_v, $time);
        end
        if (exp_v || exp_zero) begin
            nvec++;
            if (taps_now() !== (exp_zero ? 72'h0 : exp_taps)) begin
                nerr++;
                $display("FAIL taps: got %h want %h at %0t", taps_now(),
                         exp_zero ? 72'h0 : exp_taps, $time);
            end
        end
        if (exp_v) begin
            if (strobe_cnt == 0) first_taps = taps_now();
            last_taps = taps_now();
            strobe_cnt++;
            if (got32 && mrow == 3 && mcol == 3) cap32 = taps_now();
        end
`ifdef WINDOW_WIN_CNT_EN
        nvec++;
        if (int'(win_count) !== exp_wc) begin
            nerr++;
            $display("FAIL win_count: got %0d want %0d at %0t", win_count, exp_wc, $time);
        end
`endif
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b0;
            din       = 8'($urandom);
            sof       = 1'($urandom);
            @(negedge clk);
        end
        sof = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic s, input int gap);
        idle(gap);
        din = d; din_valid = 1'b1; sof = s;
        @(negedge clk);
        din_valid = 1'b0; sof = 1'b0;
    endtask

    // Send pixels of one frame from (0,0) up to but excluding (stop_r,stop_c).
    task automatic frame(input int gap_max, input logic rnd, input logic with_sof,
                         input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r * W + c < stop_r * W + stop_c)
                    send(rnd ? 8'($urandom) : 8'(r * 16 + c),
                         with_sof && r == 0 && c == 0, $urandom_range(0, gap_max));
        idle(2);
    endtask

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    localparam logic [71:0] FIRST_WIN = 72'h00_01_02_10_11_12_20_21_22;

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Continuous frame
        frame(0, 1'b0, 1'b1, H, 0);
        check("s1_count", 72'(strobe_cnt), 72'd24);
        check("s1_first", first_taps, FIRST_WIN);
        check("s1_last_p5", 72'(last_taps[39:32]), 72'h46);
        check("s1_row3_p1", 72'(cap32[71:64]), 72'h10);
        check("s1_row3_p9", 72'(cap32[7:0]), 72'h32);
`ifdef WINDOW_WIN_CNT_EN
        check("s1_win_count", 72'(win_count), 72'd24);
`endif

        // Same frame with random gaps
        frame(3, 1'b0, 1'b1, H, 0);
        check("s2_count", 72'(strobe_cnt), 72'd24);
        check("s2_first", first_taps, FIRST_WIN);
        check("s2_last_p5", 72'(last_taps[39:32]), 72'h46);
`ifdef WINDOW_WIN_CNT_EN
        send(8'h00, 1'b1, 0);
        idle(1);
        check("s2_win_count_clr", 72'(win_count), 72'd0);
`endif

        // Mid-frame sof at (3,4), then a clean frame
        frame(1, 1'b0, 1'b1, 3, 4);
        frame(2, 1'b0, 1'b1, H, 0);
        check("s4_count", 72'(strobe_cnt), 72'd24);
        check("s4_first", first_taps, FIRST_WIN);

        // Reset pulse while at (4,5); next frame starts without sof
        frame(0, 1'b0, 1'b1, 4, 5);
        rst_n = 1'b0; din = 8'hAA; din_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; din_valid = 1'b0;
        check("s5_taps_zero", taps_now(), 72'h0);
        check("s5_dv_zero", 72'(dout_valid), 72'h0);
        frame(0, 1'b0, 1'b0, H, 0);
        check("s5_count", 72'(strobe_cnt), 72'd24);
        check("s5_first", first_taps, FIRST_WIN);
        check("s5_last_p5", 72'(last_taps[39:32]), 72'h46);

        // Random pixel data with random gaps
        for (int f = 0; f < 3; f++) begin
            frame(3, 1'b1, 1'b1, H, 0);
            check("s6_count", 72'(strobe_cnt), 72'd24);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
